if_fetch: RTL and testbench

- Instruction-fetch stage. Generates the PC and assembles each 32-bit instruction from a byte-wide memory port.
- Presents {pc, inst} to the IF/ID register, which the decode stage consumes.
- Accepts the decode stage's redirect pair (branch flag + target) and restarts fetch at the target.
- Sole producer of decode's pc/inst inputs and sole consumer of its branch outputs.

---
 rtl/if_fetch_pkg.sv | 45 ++++
 rtl/if_fetch_byte_assembler.sv | 41 ++++
 rtl/if_fetch.sv | 112 +++++++++++
 tb/tb_if_fetch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch slice: bus widths, reset level,
// the fetch-state encoding and small helpers for walking the byte states.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;   // InstAddrBus
    localparam int INST_W      = 32;   // InstBus
    localparam int MEM_BYTE_W  = 8;    // MemByteBus

    localparam logic                   RST_ENABLE    = 1'b1;
    localparam logic [INST_W-1:0]      ZERO_WORD     = '0;
    localparam logic [INST_ADDR_W-1:0] NOP_INST_ADDR = '0;

    // IfStateBus: BYTE0..BYTE3 collect one byte each, VALID presents the word.
    typedef enum logic [2:0] {
        IF_BYTE0 = 3'd0,
        IF_BYTE1 = 3'd1,
        IF_BYTE2 = 3'd2,
        IF_BYTE3 = 3'd3,
        IF_VALID = 3'd4
    } if_state_t;

    // Byte offset (from pc) fetched in a BYTEn state; VALID maps to 0.
    function automatic logic [1:0] byte_lane(input if_state_t s);
        case (s)
            IF_BYTE1: byte_lane = 2'd1;
            IF_BYTE2: byte_lane = 2'd2;
            IF_BYTE3: byte_lane = 2'd3;
            default:  byte_lane = 2'd0;
        endcase
    endfunction

    // State entered once the current byte has been accepted.
    function automatic if_state_t next_byte_state(input if_state_t s);
        case (s)
            IF_BYTE0: next_byte_state = IF_BYTE1;
            IF_BYTE1: next_byte_state = IF_BYTE2;
            IF_BYTE2: next_byte_state = IF_BYTE3;
            default:  next_byte_state = IF_VALID;
        endcase
    endfunction

endpackage

// File: rtl/if_fetch_byte_assembler.sv
// -----------------------------------------------------------------------------
// if_byte_assembler
// Four byte lanes forming a little-endian 32-bit word; lane n holds
// word[8n+7:8n]. Kept separate so a later load unit can reuse it.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, clears the word
//   clr      synchronous clear (discard partially collected bytes)
//   lane_we  per-lane write enable, at most one lane expected per cycle
//   byte_in  byte written into every enabled lane
//   word     assembled word
// -----------------------------------------------------------------------------
module if_byte_assembler
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [3:0]  lane_we,
    input  logic [7:0]  byte_in,
    output logic [31:0] word
);

    // NOTE: this is a 32-bit register, not a RAM, so it is reset; a real memory
    // array would be left unreset and only its valid tracking cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            word <= ZERO_WORD;
        end else if (clr) begin
            word <= ZERO_WORD;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    word[8*i +: 8] <= byte_in;
                end
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage. Walks BYTE0..BYTE3 reading pc+n from a byte-wide
// memory port, then presents {pc, inst} in VALID until the pipeline accepts it.
// A decode redirect restarts fetch at the branch target from any state.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall_i           hold the presented instruction in VALID
//   branch_flag_i     redirect request (highest priority)
//   branch_target_i   redirect target, fetched bytewise as-is (no alignment)
//   mem_req_o         byte read request (BYTEn states only)
//   mem_addr_o        byte address, pc + n
//   mem_ready_i       mem_data_i valid for mem_addr_o this cycle
//   mem_data_i        returned byte
//   pc_o, inst_o      presented PC and little-endian instruction
//   inst_valid_o      pc_o/inst_o valid (VALID state)
//   if_stall_req_o    high while no instruction is available
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [7:0]        mem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic              if_stall_req_o
);

    if_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        lane_we;
    logic              lane_clr;
    logic              fetching;

    assign fetching = (state_q != IF_VALID);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= IF_BYTE0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        lane_we  = 4'b0000;
        lane_clr = 1'b0;

        if (branch_flag_i) begin
            // Redirect wins over a same-cycle byte return and over stall_i.
            state_d  = IF_BYTE0;
            pc_d     = branch_target_i;
            lane_clr = 1'b1;
        end else begin
            case (state_q)
                IF_BYTE0, IF_BYTE1, IF_BYTE2, IF_BYTE3: begin
                    if (mem_ready_i) begin
                        lane_we = 4'b0001 << byte_lane(state_q);
                        state_d = next_byte_state(state_q);
                    end
                end
                IF_VALID: begin
                    if (!stall_i) begin
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = IF_BYTE0;
                    end
                end
                default: begin
                    state_d = IF_BYTE0;
                end
            endcase
        end
    end

    if_byte_assembler u_byte_assembler (
        .clk     (clk),
        .rst     (rst),
        .clr     (lane_clr),
        .lane_we (lane_we),
        .byte_in (mem_data_i),
        .word    (inst_o)
    );

    // The state already sits in BYTE0 during reset; gating with rst keeps the
    // request low until reset releases, after which fetch begins immediately.
    assign mem_req_o      = fetching && (rst != RST_ENABLE);
    assign mem_addr_o     = pc_q + ADDR_W'(byte_lane(state_q));
    assign pc_o           = pc_q;
    assign inst_valid_o   = !fetching;
    assign if_stall_req_o = fetching;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
// Directed scenarios followed by randomized stimulus. The reference model only
// tracks the fetch PC and how many bytes of the current word have been taken;
// the expected instruction is read straight from the bench's memory image.
// -----------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [7:0]  mem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        if_stall_req_o;

    int n_checks = 0;
    int n_errors = 0;

    // Memory image: explicit bytes where a test needs them, a hash elsewhere.
    logic [7:0] mem_ovr [logic [31:0]];

    // Reference model state.
    logic [31:0] m_pc;
    int          m_cnt;   // bytes of the current word accepted; 4 = presented

    always #5 clk = ~clk;

    if_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ready_i     (mem_ready_i),
        .mem_data_i      (mem_data_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o),
        .if_stall_req_o  (if_stall_req_o)
    );

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called away from the rising edge), then
    // advance to the next falling edge.
    task automatic tick(input logic br, input logic [31:0] tgt, input logic rdy, input logic stl);
        branch_flag_i   = br;
        branch_target_i = tgt;
        mem_ready_i     = rdy;
        stall_i         = stl;
        mem_data_i      = byte_at(mem_addr_o);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inst"},      inst_o,                  32'h0);
        check({tag, "_pc"},        pc_o,                    32'h0);
        check({tag, "_valid"},     32'(inst_valid_o),       32'h0);
        check({tag, "_req"},       32'(mem_req_o),          32'h0);
        check({tag, "_addr"},      mem_addr_o,              32'h0);
        check({tag, "_stall_req"}, 32'(if_stall_req_o),     32'h1);
    endtask

    // Reference model: advances on the same edge as the DUT from the spec rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc  = 32'h0;
            m_cnt = 0;
        end else if (branch_flag_i) begin
            m_pc  = branch_target_i;
            m_cnt = 0;
        end else if (m_cnt == 4) begin
            if (!stall_i) begin
                m_pc  = m_pc + 32'd4;
                m_cnt = 0;
            end
        end else if (mem_ready_i) begin
            m_cnt = m_cnt + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            check_reset_values("cmp_rst");
        end else begin
            check("cmp_req",       32'(mem_req_o),               32'(m_cnt < 4));
            check("cmp_valid",     32'(inst_valid_o),            32'(m_cnt == 4));
            check("cmp_stall_req", 32'(if_stall_req_o),          32'(m_cnt < 4));
            check("cmp_req_valid", 32'(mem_req_o & inst_valid_o), 32'h0);
            if (m_cnt < 4) begin
                check("cmp_addr", mem_addr_o, m_pc + 32'(m_cnt));
            end else begin
                check("cmp_pc",   pc_o,   m_pc);
                check("cmp_inst", inst_o, word_at(m_pc));
            end
        end
    end

    initial begin
        logic [31:0] tgt;

        mem_ovr[32'h0000_0000] = 8'h13; mem_ovr[32'h0000_0001] = 8'h05;
        mem_ovr[32'h0000_0002] = 8'h00; mem_ovr[32'h0000_0003] = 8'h00;
        mem_ovr[32'h0000_0004] = 8'h93; mem_ovr[32'h0000_0005] = 8'h00;
        mem_ovr[32'h0000_0006] = 8'h10; mem_ovr[32'h0000_0007] = 8'h00;
        mem_ovr[32'h0000_1000] = 8'h37; mem_ovr[32'h0000_1001] = 8'h01;
        mem_ovr[32'h0000_1002] = 8'h00; mem_ovr[32'h0000_1003] = 8'h00;
        mem_ovr[32'h0000_1004] = 8'h13; mem_ovr[32'h0000_1005] = 8'h00;
        mem_ovr[32'h0000_1006] = 8'h00; mem_ovr[32'h0000_1007] = 8'h00;

        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        mem_ready_i     = 1'b0;
        mem_data_i      = 8'h00;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        #1 rst = 1'b0;
        #1;

        // 1-cycle memory from reset: addresses 0..3, word valid in cycle 5.
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", mem_addr_o, 32'(i));
            check("t1_req",  32'(mem_req_o), 32'h1);
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("t1_valid", 32'(inst_valid_o), 32'h1);
        check("t1_pc",    pc_o,   32'h0);
        check("t1_inst",  inst_o, 32'h0000_0513);
        check("t1_req0",  32'(mem_req_o), 32'h0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        check("t1_next_addr", mem_addr_o, 32'h4);

        // 3 wait cycles per byte: address held, valid after 16 cycles.
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 3; w++) begin
                tick(1'b0, 32'h0, 1'b0, 1'b0);
                check("t2_addr_hold", mem_addr_o, 32'(4 + b));
                check("t2_not_valid", 32'(inst_valid_o), 32'h0);
            end
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("t2_valid", 32'(inst_valid_o), 32'h1);
        check("t2_inst",  inst_o, 32'h0010_0093);

        // Stall for 4 cycles in VALID (ready toggling must be ignored).
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 32'h0, 1'(i), 1'b1);
            check("t3_valid", 32'(inst_valid_o), 32'h1);
            check("t3_pc",    pc_o,   32'h4);
            check("t3_inst",  inst_o, 32'h0010_0093);
            check("t3_req",   32'(mem_req_o), 32'h0);
        end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_advance", mem_addr_o, 32'h8);

        // Redirect in BYTE2 with a simultaneous byte return.
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_byte2_addr", mem_addr_o, 32'hA);
        tick(1'b1, 32'h0000_1000, 1'b1, 1'b0);
        check("t4_redir_addr",  mem_addr_o, 32'h1000);
        check("t4_redir_valid", 32'(inst_valid_o), 32'h0);
        repeat (4) tick(1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_pc",   pc_o,   32'h1000);
        check("t4_inst", inst_o, 32'h0000_0137);

        // Redirect while VALID and stalled, to a misaligned target.
        tick(1'b1, 32'h0000_1002, 1'b0, 1'b1);
        check("t5_valid", 32'(inst_valid_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("t5_addr", mem_addr_o, 32'h1002 + 32'(i));
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("t5_pc",   pc_o,   32'h1002);
        check("t5_inst", inst_o, 32'h0013_0000);

        // Async reset mid-BYTE1, then restart at RESET_PC.
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        check("t6_byte1_addr", mem_addr_o, 32'h1007);
        mem_ready_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("t6_async");
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("t6_restart_addr", mem_addr_o, 32'h0);
        check("t6_restart_req",  32'(mem_req_o), 32'h1);

        // PC wrap at the top of the address space.
        tick(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 32'h0, 1'b1, 1'b0);
        check("t7_pc", pc_o, 32'hFFFF_FFFC);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        check("t7_wrap_addr", mem_addr_o, 32'h0);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(3))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                default: tgt = 32'($urandom_range(255));
            endcase
            tick($urandom_range(19) == 0, tgt, 1'($urandom_range(1)),
                 $urandom_range(9) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
